// File: rtl/dl_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ti99_dl_pkg
// Description : Shared types for the download/CPU RAM arbiter: arbiter states,
//               download FIFO entry, default region bases, index decode.
// Revision    : 1.0 - initial release
// ============================================================================
package ti99_dl_pkg;

    localparam int c_DL_ADDR_W = 17;

    localparam logic [c_DL_ADDR_W-1:0] c_BASE_C = 17'h00000;
    localparam logic [c_DL_ADDR_W-1:0] c_BASE_D = 17'h01000;
    localparam logic [c_DL_ADDR_W-1:0] c_BASE_G = 17'h0B000;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        LOAD  = 3'd2,
        FLUSH = 3'd3,
        HOLD  = 3'd4
    } dl_state_t;

    typedef enum logic [1:0] {
        REGION_C = 2'd0,
        REGION_D = 2'd1,
        REGION_G = 2'd2
    } dl_region_t;

    // lane = 1 selects the upper byte of the RAM word (even byte address)
    typedef struct packed {
        logic [c_DL_ADDR_W-1:0] addr;
        logic                   lane;
        logic [7:0]             data;
    } dl_entry_t;

    function automatic dl_region_t index_region(input logic [1:0] index);
        case (index)
            2'd2:    return REGION_D;
            2'd3:    return REGION_G;
            default: return REGION_C;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dl_ram_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dl_fifo
// Description : Synchronous first-word-fall-through FIFO of download entries.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_fifo
    import ti99_dl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  dl_entry_t        din,
    output dl_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dl_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk_sys) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dl_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dl_ram_arbiter
// Description : Shares the CPU RAM port between the ep994a CPU and the HPS
//               ioctl download stream, and sequences the console hold-reset.
// Options     : DL_CHECKSUM_EN adds the dl_sum download checksum output.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_ram_arbiter
    import ti99_dl_pkg::*;
#(
    parameter int                ADDR_W      = c_DL_ADDR_W,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                HOLD_CYCLES = 255,
    parameter logic [ADDR_W-1:0] BASE_C      = c_BASE_C,
    parameter logic [ADDR_W-1:0] BASE_D      = c_BASE_D,
    parameter logic [ADDR_W-1:0] BASE_G      = c_BASE_G
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic              cpu_ce_n,
    input  logic              cpu_we_n,
    input  logic [1:0]        cpu_be_n,
    input  logic [15:0]       cpu_d,
    output logic [15:0]       cpu_q,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_we,
    output logic [1:0]        ram_be,
    output logic [15:0]       ram_d,
    input  logic [15:0]       ram_q,
`ifdef DL_CHECKSUM_EN
    output logic [15:0]       dl_sum,
`endif
    output logic              console_reset,
    output logic              dl_busy,
    output logic              dl_overflow
);

    localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 2);

    dl_state_t           r_state;
    dl_state_t           w_state_next;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_overflow;

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic                w_load_entry;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_word;
    dl_entry_t           w_entry;
    dl_entry_t           w_head;
    logic [c_CNT_W-1:0]  w_unused_count;
    logic                w_unused_idx;

    assign w_unused_idx = ^ioctl_index[7:2];

    // bytes beyond 256 KiB of a file have no RAM region and are discarded
    assign w_accept = ioctl_wr && (ioctl_addr[24:18] == 7'd0);
    assign w_push   = w_accept;
    assign w_pop    = cpu_ce_n && !w_empty;
    assign w_drop   = w_accept && w_full && !w_pop;

    always_comb begin
        w_base = BASE_C;
        case (index_region(ioctl_index[1:0]))
            REGION_D: w_base = BASE_D;
            REGION_G: w_base = BASE_G;
            default:  w_base = BASE_C;
        endcase
    end

    assign w_word        = ADDR_W'(ioctl_addr[17:1]) + w_base;
    assign w_entry.addr  = c_DL_ADDR_W'(w_word);
    assign w_entry.lane  = ~ioctl_addr[0];
    assign w_entry.data  = ioctl_dout;

    dl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (c_CNT_W)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_entry),
        .head    (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_unused_count)
    );

    // CPU always wins; the download stream only uses cycles the CPU leaves idle
    always_comb begin
        ram_a  = cpu_a;
        ram_we = 1'b0;
        ram_be = ~cpu_be_n;
        ram_d  = cpu_d;
        if (!cpu_ce_n) begin
            ram_we = ~cpu_we_n;
        end else if (!w_empty) begin
            ram_a  = ADDR_W'(w_head.addr);
            ram_we = 1'b1;
            ram_be = w_head.lane ? 2'b10 : 2'b01;
            ram_d  = {w_head.data, w_head.data};
        end
    end

    assign cpu_q = ram_q;

    always_comb begin
        w_state_next  = r_state;
        console_reset = 1'b1;
        dl_busy       = 1'b0;
        case (r_state)
            BOOT: begin
                if (ioctl_download) w_state_next = LOAD;
            end
            RUN: begin
                console_reset = 1'b0;
                if (ioctl_download) w_state_next = LOAD;
            end
            LOAD: begin
                dl_busy = 1'b1;
                if (!ioctl_download) w_state_next = FLUSH;
            end
            FLUSH: begin
                dl_busy = 1'b1;
                if (ioctl_download)  w_state_next = LOAD;
                else if (w_empty)    w_state_next = HOLD;
            end
            HOLD: begin
                if (ioctl_download)                        w_state_next = LOAD;
                else if (r_hold_cnt <= c_HOLD_W'(1))       w_state_next = RUN;
            end
            default: w_state_next = BOOT;
        endcase
    end

    assign w_load_entry = (w_state_next == LOAD) && (r_state != LOAD);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= BOOT;
            r_hold_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == FLUSH) && (w_state_next == HOLD)) begin
                r_hold_cnt <= c_HOLD_W'(HOLD_CYCLES);
            end else if ((r_state == HOLD) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - c_HOLD_W'(1);
            end
            // a FLUSH->LOAD resume continues the same session, so keep the flag
            if (w_load_entry && (r_state != FLUSH)) begin
                r_overflow <= w_drop;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign dl_overflow = r_overflow;

`ifdef DL_CHECKSUM_EN
    logic [15:0] r_sum;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_load_entry) begin
            r_sum <= w_accept ? {8'd0, ioctl_dout} : 16'd0;
        end else if (w_accept) begin
            r_sum <= r_sum + {8'd0, ioctl_dout};
        end
    end

    assign dl_sum = r_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dl_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dl_ram_arbiter
// Description : Scoreboard bench for dl_ram_arbiter: a reference model queues
//               expected download writes, a monitor checks the RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dl_ram_arbiter;

    localparam int ADDR_W      = 17;
    localparam int FIFO_DEPTH  = 4;
    localparam int HOLD_CYCLES = 255;

    logic              clk_sys = 1'b0;
    logic              reset = 1'b1;
    logic              ioctl_download = 1'b0;
    logic [7:0]        ioctl_index = '0;
    logic              ioctl_wr = 1'b0;
    logic [24:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_dout = '0;
    logic [ADDR_W-1:0] cpu_a = '0;
    logic              cpu_ce_n = 1'b1;
    logic              cpu_we_n = 1'b1;
    logic [1:0]        cpu_be_n = 2'b11;
    logic [15:0]       cpu_d = '0;
    logic [15:0]       cpu_q;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_we;
    logic [1:0]        ram_be;
    logic [15:0]       ram_d;
    logic [15:0]       ram_q = 16'hA5C3;
    logic              console_reset;
    logic              dl_busy;
    logic              dl_overflow;
`ifdef DL_CHECKSUM_EN
    logic [15:0]       dl_sum;
    logic [15:0]       exp_sum;
`endif

    dl_ram_arbiter #(
        .ADDR_W      (ADDR_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .cpu_a          (cpu_a),
        .cpu_ce_n       (cpu_ce_n),
        .cpu_we_n       (cpu_we_n),
        .cpu_be_n       (cpu_be_n),
        .cpu_d          (cpu_d),
        .cpu_q          (cpu_q),
        .ram_a          (ram_a),
        .ram_we         (ram_we),
        .ram_be         (ram_be),
        .ram_d          (ram_d),
        .ram_q          (ram_q),
`ifdef DL_CHECKSUM_EN
        .dl_sum         (dl_sum),
`endif
        .console_reset  (console_reset),
        .dl_busy        (dl_busy),
        .dl_overflow    (dl_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [16:0] a;
        logic [1:0]  be;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks  = 0;
    int  n_fail    = 0;
    int  model_cnt = 0;
    bit  mon_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected RAM write for one download byte, straight from the address map
    function automatic wr_t ref_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] b);
        wr_t r;
        int  base;
        case (idx % 4)
            2:       base = 'h1000;
            3:       base = 'hB000;
            default: base = 'h0000;
        endcase
        r.a  = 17'((base + int'(a / 2)) % (1 << 17));
        r.be = (a % 2 == 0) ? 2'b10 : 2'b01;
        r.d  = {b, b};
        return r;
    endfunction

    // Reference model: tracks FIFO occupancy and queues every byte it keeps
    always @(posedge clk_sys) begin : b_model
        bit pop;
        if (reset) begin
            model_cnt = 0;
            exp_q.delete();
        end else begin
            pop = cpu_ce_n && (model_cnt > 0);
            if (ioctl_wr && (ioctl_addr / (1 << 18) == 0)) begin
                if (model_cnt < FIFO_DEPTH || pop) begin
                    exp_q.push_back(ref_write(ioctl_index, ioctl_addr, ioctl_dout));
                    model_cnt++;
                end
            end
            if (pop) model_cnt--;
        end
    end

    // Monitor: every cycle, check the RAM port against CPU or the scoreboard
    always @(negedge clk_sys) begin : b_monitor
        wr_t        e;
        logic [1:0] nbe;
        if (mon_en) begin
            check("cpu_q", cpu_q, ram_q);
            if (!cpu_ce_n) begin
                nbe = ~cpu_be_n;
                check("cpu_ram_a", ram_a, cpu_a);
                check("cpu_ram_we", ram_we, !cpu_we_n);
                check("cpu_ram_be", ram_be, nbe);
                check("cpu_ram_d", ram_d, cpu_d);
            end else begin
                check("dl_ram_we", ram_we, exp_q.size() > 0);
                if (ram_we && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("dl_ram_a", ram_a, e.a);
                    check("dl_ram_be", ram_be, e.be);
                    check("dl_ram_d", ram_d, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] b);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = b;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    // Drop download with the FIFO already drained. Sample 1 is still LOAD,
    // sample 2 is FLUSH (sees empty), then HOLD_CYCLES of HOLD, then RUN.
    task automatic drop_and_measure(input string name);
        int n;
        n = 0;
        ioctl_download = 1'b0;
        while (n < 1000) begin
            @(negedge clk_sys);
            n++;
            if (n == 2) check({name, "_busy_flush"}, dl_busy, 1);
            if (n == 3) check({name, "_busy_hold"}, dl_busy, 0);
            if (!console_reset) break;
        end
        check({name, "_release_cycle"}, n, HOLD_CYCLES + 3);
        check({name, "_busy_run"}, dl_busy, 0);
    endtask

    initial begin : b_stim
        bit bad;

        repeat (3) tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_sys);
        check("rst_console_reset", console_reset, 1);
        check("rst_dl_busy", dl_busy, 0);
        check("rst_dl_overflow", dl_overflow, 0);
        check("rst_ram_we", ram_we, 0);
        bad = 1'b0;
        repeat (40) begin
            tick();
            if (!console_reset) bad = 1'b1;
        end
        check("boot_console_held", bad, 0);

        // Two bytes into index 2, CPU idle, then post-load hold timing
        ioctl_download = 1'b1;
        tick();
        check("load_busy", dl_busy, 1);
        strobe(8'd2, 25'd0, 8'h12);
        strobe(8'd2, 25'd1, 8'h34);
        repeat (4) tick();
        check("idx2_drained", exp_q.size(), 0);
        drop_and_measure("hold1");

        // CPU holds the port while six bytes arrive back to back
        tick();
        ioctl_download = 1'b1;
        cpu_ce_n       = 1'b0;
        cpu_we_n       = 1'b1;
        cpu_a          = 17'h0_0ABC;
        tick();
        for (int i = 0; i < 6; i++) strobe(8'd0, 25'(i), 8'($urandom));
        check("contention_overflow", dl_overflow, 1);
        check("contention_pending", exp_q.size(), FIFO_DEPTH);
        cpu_ce_n = 1'b1;
        repeat (6) tick();
        check("contention_drained", exp_q.size(), 0);

        // Re-download while the hold counter sits at 100
        ioctl_download = 1'b0;
        bad = 1'b0;
        for (int k = 1; k <= HOLD_CYCLES + 2 - 100; k++) begin
            tick();
            if (!console_reset) bad = 1'b1;
        end
        check("redl_in_hold", dl_busy, 0);
        ioctl_download = 1'b1;
        tick();
        check("redl_console_continuous", bad | !console_reset, 0);
        check("redl_overflow_cleared", dl_overflow, 0);
        check("redl_busy", dl_busy, 1);

        // Out-of-range byte is ignored; index 3 byte 2 maps to word B001
        strobe(8'd3, 25'h40000, 8'h77);
        strobe(8'd3, 25'd2, 8'h5A);
        repeat (3) tick();
        check("oor_overflow", dl_overflow, 0);
        check("oor_drained", exp_q.size(), 0);

        // Reset with three entries queued behind a busy CPU
        cpu_ce_n = 1'b0;
        for (int i = 0; i < 3; i++) strobe(8'd1, 25'(16 + i), 8'($urandom));
        check("pre_reset_pending", exp_q.size(), 3);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick();
        reset    = 1'b0;
        cpu_ce_n = 1'b1;
        @(negedge clk_sys);
        check("post_reset_ram_we", ram_we, 0);
        check("post_reset_console", console_reset, 1);
        check("post_reset_busy", dl_busy, 0);
        tick();

        // 257 bytes of 0xFF into a fresh session
        ioctl_download = 1'b1;
        tick();
`ifdef DL_CHECKSUM_EN
        exp_sum = 16'd0;
`endif
        for (int i = 0; i < 257; i++) begin
            strobe(8'd0, 25'(i), 8'hFF);
`ifdef DL_CHECKSUM_EN
            exp_sum = exp_sum + 16'h00FF;
`endif
        end
        repeat (3) tick();
        check("sum_run_overflow", dl_overflow, 0);
`ifdef DL_CHECKSUM_EN
        check("dl_sum", dl_sum, exp_sum);
`endif

        // Randomised traffic on both requesters
        for (int i = 0; i < 600; i++) begin
            ioctl_wr    = ($urandom % 3) != 0;
            ioctl_index = 8'($urandom);
            ioctl_addr  = (($urandom % 8) == 0) ? 25'($urandom) : {7'd0, 18'($urandom)};
            ioctl_dout  = 8'($urandom);
            cpu_ce_n    = ($urandom % 5) < 2 ? 1'b0 : 1'b1;
            cpu_we_n    = 1'($urandom);
            cpu_be_n    = 2'($urandom);
            cpu_a       = 17'($urandom);
            cpu_d       = 16'($urandom);
            ram_q       = 16'($urandom);
            tick();
        end
        ioctl_wr = 1'b0;
        cpu_ce_n = 1'b1;
        repeat (8) tick();
        check("random_drained", exp_q.size(), 0);
        drop_and_measure("hold2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
